// File: rtl/proc_mem_port_arbiter_pkg.sv
// proc_mem_port_arbiter_pkg: shared types and constants for the processor memory-port arbiter.
// Holds the 4-byte memory request/response message formats, the requester ids and the
// grant-lock state encoding, plus a small helper used by the round-robin pointer.
package proc_mem_port_arbiter_pkg;

  // Requester ids; these values are what the tag FIFO stores per in-flight request.
  localparam logic ARB_ID_IMEM = 1'b0;
  localparam logic ARB_ID_DMEM = 1'b1;

  typedef enum logic [2:0] {
    MEM_TYPE_READ  = 3'd0,
    MEM_TYPE_WRITE = 3'd1,
    MEM_TYPE_INIT  = 3'd2,
    MEM_TYPE_AMO   = 3'd3
  } mem_type_t;

  typedef struct packed {
    mem_type_t   msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    mem_type_t   msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Grant lock: HELD while a granted request is stalled downstream.
  typedef enum logic [0:0] {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  // The requester that is not 'id'; round-robin favours it after id wins.
  function automatic logic arb_other(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/proc_mem_port_arbiter_if.sv
// proc_mem_port_arbiter_if: bundles the two requester ports and the shared downstream port.
// Ports: imem req/resp, dmem req/resp, downstream memreq/memresp (msg/val/rdy each).
// Modports: slave = arbiter view, master = processor + memory environment view.
interface proc_mem_port_arbiter_if;

  proc_mem_port_arbiter_pkg::mem_req_4B_t  imemreq_msg;
  logic                                    imemreq_val;
  logic                                    imemreq_rdy;
  proc_mem_port_arbiter_pkg::mem_resp_4B_t imemresp_msg;
  logic                                    imemresp_val;
  logic                                    imemresp_rdy;

  proc_mem_port_arbiter_pkg::mem_req_4B_t  dmemreq_msg;
  logic                                    dmemreq_val;
  logic                                    dmemreq_rdy;
  proc_mem_port_arbiter_pkg::mem_resp_4B_t dmemresp_msg;
  logic                                    dmemresp_val;
  logic                                    dmemresp_rdy;

  proc_mem_port_arbiter_pkg::mem_req_4B_t  memreq_msg;
  logic                                    memreq_val;
  logic                                    memreq_rdy;
  proc_mem_port_arbiter_pkg::mem_resp_4B_t memresp_msg;
  logic                                    memresp_val;
  logic                                    memresp_rdy;

  modport slave (
    input  imemreq_msg, imemreq_val, output imemreq_rdy,
    output imemresp_msg, imemresp_val, input imemresp_rdy,
    input  dmemreq_msg, dmemreq_val, output dmemreq_rdy,
    output dmemresp_msg, dmemresp_val, input dmemresp_rdy,
    output memreq_msg, memreq_val, input memreq_rdy,
    input  memresp_msg, memresp_val, output memresp_rdy
  );

  modport master (
    output imemreq_msg, imemreq_val, input imemreq_rdy,
    input  imemresp_msg, imemresp_val, output imemresp_rdy,
    output dmemreq_msg, dmemreq_val, input dmemreq_rdy,
    input  dmemresp_msg, dmemresp_val, output dmemresp_rdy,
    input  memreq_msg, memreq_val, output memreq_rdy,
    output memresp_msg, memresp_val, input memresp_rdy
  );

endinterface

// File: rtl/proc_mem_arb_tag_fifo.sv
// proc_mem_arb_tag_fifo: in-order FIFO of 1-bit requester ids for requests in flight downstream.
// Latency: head (deq_dat) reflects an enqueue on the next cycle; count is registered.
// Backpressure: full/empty flags; enqueue when full and dequeue when empty are ignored.
// Ports: clk, reset (async active-low), enq_val/enq_dat, deq_val/deq_dat, full, empty, count.
module proc_mem_arb_tag_fifo #(
  parameter int p_depth = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_val,
  input  logic                       enq_dat,
  input  logic                       deq_val,
  output logic                       deq_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(p_depth):0]   count
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = AW + 1;

  logic [p_depth-1:0] mem;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               enq_ok;
  logic               deq_ok;

  assign full    = (count == CW'(p_depth));
  assign empty   = (count == '0);
  assign enq_ok  = enq_val && !full;
  assign deq_ok  = deq_val && !empty;
  assign deq_dat = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_ok) begin
        mem[wr_ptr] <= enq_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (deq_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq_ok, deq_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/proc_mem_port_arbiter.sv
// proc_mem_port_arbiter: shares one downstream memory port between the imem and dmem request streams.
// Latency: 0 cycles on both request and response paths (combinational pass-through, no message storage).
// Backpressure: a stalled grant is locked until accepted; a full tag FIFO blocks grants; responses wait on the head requester's rdy.
// Ports: clk, reset (async active-low), port (slave modport: imem/dmem requester ports + downstream port),
//        num_outstanding (registered in-flight count), resp_error (sticky: response seen with nothing in flight).
module proc_mem_port_arbiter
  import proc_mem_port_arbiter_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  proc_mem_port_arbiter_if.slave               port,
  output logic [$clog2(p_max_outstanding):0]   num_outstanding,
  output logic                                 resp_error
);

  localparam int CNT_W = $clog2(p_max_outstanding) + 1;

  lock_state_t      lock_state;
  lock_state_t      lock_next;
  logic             locked_id;
  logic             locked_id_next;
  logic             rr_ptr;

  logic             grant;
  logic             granted_val;
  logic             can_issue;
  logic             req_val_int;
  logic             req_fire;

  logic             fifo_full;
  logic             fifo_empty;
  logic             head_id;
  logic [CNT_W-1:0] fifo_count;
  logic             resp_rdy_int;
  logic             resp_fire;

  // ---------------------------------------------------------------- request side
  // A full tag FIFO blocks new grants even if a response drains an entry this
  // cycle; the freed slot is usable from the next cycle.
  assign can_issue = !fifo_full;

  always_comb begin
    grant = rr_ptr;
    if (lock_state == LOCK_HELD) begin
      grant = locked_id;
    end else if (port.imemreq_val && !port.dmemreq_val) begin
      grant = ARB_ID_IMEM;
    end else if (port.dmemreq_val && !port.imemreq_val) begin
      grant = ARB_ID_DMEM;
    end
  end

  assign granted_val = (grant == ARB_ID_DMEM) ? port.dmemreq_val : port.imemreq_val;

  // Internal handshake terms exclude reset so reset only reaches flops through
  // their async input; the visible val/rdy outputs are forced low during reset.
  assign req_val_int = granted_val && can_issue;
  assign req_fire    = req_val_int && port.memreq_rdy;

  assign port.memreq_msg  = (grant == ARB_ID_DMEM) ? port.dmemreq_msg : port.imemreq_msg;
  assign port.memreq_val  = reset && req_val_int;
  assign port.imemreq_rdy = reset && (grant == ARB_ID_IMEM) && port.memreq_rdy && can_issue;
  assign port.dmemreq_rdy = reset && (grant == ARB_ID_DMEM) && port.memreq_rdy && can_issue;

  // Grant lock keeps the downstream message stable while it is stalled, even if
  // the other requester becomes valid or the round-robin pointer would prefer it.
  always_comb begin
    lock_next      = lock_state;
    locked_id_next = locked_id;
    case (lock_state)
      LOCK_OPEN: begin
        if (req_val_int && !port.memreq_rdy) begin
          lock_next      = LOCK_HELD;
          locked_id_next = grant;
        end
      end
      LOCK_HELD: begin
        if (req_fire) begin
          lock_next = LOCK_OPEN;
        end
      end
      default: begin
        lock_next = LOCK_OPEN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_state <= LOCK_OPEN;
      locked_id  <= ARB_ID_IMEM;
      rr_ptr     <= ARB_ID_IMEM;
    end else begin
      lock_state <= lock_next;
      locked_id  <= locked_id_next;
      if (req_fire) begin
        rr_ptr <= arb_other(grant);
      end
    end
  end

  // ---------------------------------------------------------------- tag FIFO
  proc_mem_arb_tag_fifo #(
    .p_depth (p_max_outstanding)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .enq_val (req_fire),
    .enq_dat (grant),
    .deq_val (resp_fire),
    .deq_dat (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign num_outstanding = fifo_count;

  // ---------------------------------------------------------------- response side
  // Responses return in request order, so the FIFO head names the destination.
  // Both requesters see the response message; only the valid is steered.
  assign resp_rdy_int = !fifo_empty &&
                        ((head_id == ARB_ID_DMEM) ? port.dmemresp_rdy : port.imemresp_rdy);
  assign resp_fire    = port.memresp_val && resp_rdy_int;

  assign port.memresp_rdy  = reset && resp_rdy_int;
  assign port.imemresp_msg = port.memresp_msg;
  assign port.dmemresp_msg = port.memresp_msg;
  assign port.imemresp_val = reset && !fifo_empty && (head_id == ARB_ID_IMEM) && port.memresp_val;
  assign port.dmemresp_val = reset && !fifo_empty && (head_id == ARB_ID_DMEM) && port.memresp_val;

  // A response with nothing in flight means the downstream protocol broke;
  // flag it and hold the flag until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_error <= 1'b0;
    end else if (port.memresp_val && fifo_empty) begin
      resp_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_mem_port_arbiter.sv
// tb_proc_mem_port_arbiter: self-checking bench for proc_mem_port_arbiter.
// Inputs are driven on the falling edge and outputs sampled 1 time unit later.
// Expected destinations/data are pushed to a scoreboard at request time and checked as responses return.
module tb_proc_mem_port_arbiter;
  import proc_mem_port_arbiter_pkg::*;

  localparam int P_MAX = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] num_outstanding;
  logic       resp_error;

  proc_mem_port_arbiter_if bus ();

  proc_mem_port_arbiter #(
    .p_max_outstanding (P_MAX)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .port            (bus),
    .num_outstanding (num_outstanding),
    .resp_error      (resp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } sb_t;

  sb_t sbq[$];
  int  vectors     = 0;
  int  miscompares = 0;

  function automatic mem_req_4B_t mk_req(input logic [31:0] a);
    mem_req_4B_t r;
    r          = '0;
    r.msg_type = MEM_TYPE_READ;
    r.opaque   = a[9:2];
    r.addr     = a;
    return r;
  endfunction

  function automatic mem_resp_4B_t mk_resp(input logic [31:0] d);
    mem_resp_4B_t r;
    r          = '0;
    r.msg_type = MEM_TYPE_READ;
    r.data     = d;
    return r;
  endfunction

  task automatic drive_idle();
    bus.imemreq_msg  = '0;
    bus.imemreq_val  = 1'b0;
    bus.imemresp_rdy = 1'b0;
    bus.dmemreq_msg  = '0;
    bus.dmemreq_val  = 1'b0;
    bus.dmemresp_rdy = 1'b0;
    bus.memreq_rdy   = 1'b0;
    bus.memresp_msg  = '0;
    bus.memresp_val  = 1'b0;
  endtask

  // Memory model: return every scoreboarded response in order, all consumers ready.
  task automatic test_responses_in_order();
    sb_t e;
    bus.imemresp_rdy = 1'b1;
    bus.dmemresp_rdy = 1'b1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      bus.memresp_val = 1'b1;
      bus.memresp_msg = mk_resp(e.data);
      #1;
      vectors++;
      if ({bus.dmemresp_val, bus.imemresp_val} !== (e.id ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL resp_route: {d,i}val got %b want %b", {bus.dmemresp_val, bus.imemresp_val}, (e.id ? 2'b10 : 2'b01));
      end
      vectors++;
      if (bus.memresp_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL resp_rdy: got %b want 1", bus.memresp_rdy);
      end
      vectors++;
      if ((e.id ? bus.dmemresp_msg.data : bus.imemresp_msg.data) !== e.data) begin
        miscompares++;
        $display("FAIL resp_data: got %h want %h", (e.id ? bus.dmemresp_msg.data : bus.imemresp_msg.data), e.data);
      end
      @(negedge clk);
    end
    bus.memresp_val = 1'b0;
    #1;
    vectors++;
    if (num_outstanding !== 3'd0) begin
      miscompares++;
      $display("FAIL drained_count: got %0d want 0", num_outstanding);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    bus.imemreq_val  = 1'b1;
    bus.imemreq_msg  = mk_req(32'h1000);
    bus.memreq_rdy   = 1'b1;
    bus.memresp_val  = 1'b1;
    bus.imemresp_rdy = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({num_outstanding, resp_error} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_state: {count,err} got %b want 0000", {num_outstanding, resp_error});
    end
    vectors++;
    if ({bus.memreq_val, bus.imemreq_rdy, bus.memresp_rdy, bus.imemresp_val} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_handshake: got %b want 0000", {bus.memreq_val, bus.imemreq_rdy, bus.memresp_rdy, bus.imemresp_val});
    end
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [31:0] iaddr;
    logic [31:0] daddr;
    iaddr = 32'h1000;
    daddr = 32'h2000;
    bus.memreq_rdy  = 1'b1;
    bus.imemreq_val = 1'b1;
    bus.dmemreq_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic        exp_id;
      logic [31:0] exp_addr;
      exp_id   = i[0];
      exp_addr = exp_id ? daddr : iaddr;
      bus.imemreq_msg = mk_req(iaddr);
      bus.dmemreq_msg = mk_req(daddr);
      #1;
      vectors++;
      if ({bus.memreq_val, bus.memreq_msg.addr} !== {1'b1, exp_addr}) begin
        miscompares++;
        $display("FAIL contention_req[%0d]: val/addr got %b/%h want 1/%h", i, bus.memreq_val, bus.memreq_msg.addr, exp_addr);
      end
      vectors++;
      if ({bus.dmemreq_rdy, bus.imemreq_rdy} !== (exp_id ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL contention_rdy[%0d]: {d,i}rdy got %b want %b", i, {bus.dmemreq_rdy, bus.imemreq_rdy}, (exp_id ? 2'b10 : 2'b01));
      end
      sbq.push_back('{exp_id, ~exp_addr});
      if (exp_id) daddr = daddr + 32'd4;
      else        iaddr = iaddr + 32'd4;
      @(negedge clk);
    end
    drive_idle();
    #1;
    vectors++;
    if (num_outstanding !== 3'd4) begin
      miscompares++;
      $display("FAIL contention_count: got %0d want 4", num_outstanding);
    end
    @(negedge clk);
    test_responses_in_order();
  endtask

  task automatic test_lock();
    drive_idle();
    bus.dmemreq_val = 1'b1;
    bus.dmemreq_msg = mk_req(32'h2000);
    #1;
    vectors++;
    if ({bus.memreq_val, bus.memreq_msg.addr} !== {1'b1, 32'h2000}) begin
      miscompares++;
      $display("FAIL lock_first: val/addr got %b/%h want 1/00002000", bus.memreq_val, bus.memreq_msg.addr);
    end
    @(negedge clk);
    bus.imemreq_val = 1'b1;
    bus.imemreq_msg = mk_req(32'h1100);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({bus.memreq_msg.addr, bus.imemreq_rdy, bus.dmemreq_rdy} !== {32'h2000, 2'b00}) begin
        miscompares++;
        $display("FAIL lock_hold[%0d]: addr/irdy/drdy got %h/%b/%b want 00002000/0/0", i, bus.memreq_msg.addr, bus.imemreq_rdy, bus.dmemreq_rdy);
      end
      @(negedge clk);
    end
    bus.memreq_rdy = 1'b1;
    #1;
    vectors++;
    if ({bus.memreq_msg.addr, bus.dmemreq_rdy, bus.imemreq_rdy} !== {32'h2000, 2'b10}) begin
      miscompares++;
      $display("FAIL lock_release: addr/drdy/irdy got %h/%b/%b want 00002000/1/0", bus.memreq_msg.addr, bus.dmemreq_rdy, bus.imemreq_rdy);
    end
    sbq.push_back('{1'b1, ~32'h2000});
    @(negedge clk);
    bus.dmemreq_val = 1'b0;
    #1;
    vectors++;
    if ({bus.memreq_msg.addr, bus.imemreq_rdy} !== {32'h1100, 1'b1}) begin
      miscompares++;
      $display("FAIL lock_next_grant: addr/irdy got %h/%b want 00001100/1", bus.memreq_msg.addr, bus.imemreq_rdy);
    end
    sbq.push_back('{1'b0, ~32'h1100});
    @(negedge clk);
    drive_idle();
    test_responses_in_order();
  endtask

  task automatic test_full();
    sb_t e;
    drive_idle();
    bus.memreq_rdy  = 1'b1;
    bus.imemreq_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.imemreq_msg = mk_req(32'h3000 + 32'(i * 4));
      #1;
      vectors++;
      if (bus.imemreq_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL full_fill[%0d]: irdy got %b want 1", i, bus.imemreq_rdy);
      end
      sbq.push_back('{1'b0, ~(32'h3000 + 32'(i * 4))});
      @(negedge clk);
    end
    bus.imemreq_msg = mk_req(32'h3010);
    #1;
    vectors++;
    if ({bus.memreq_val, bus.imemreq_rdy, num_outstanding} !== {2'b00, 3'd4}) begin
      miscompares++;
      $display("FAIL full_block: val/irdy/count got %b/%b/%0d want 0/0/4", bus.memreq_val, bus.imemreq_rdy, num_outstanding);
    end
    @(negedge clk);
    e = sbq.pop_front();
    bus.memresp_val  = 1'b1;
    bus.memresp_msg  = mk_resp(e.data);
    bus.imemresp_rdy = 1'b1;
    #1;
    vectors++;
    if ({bus.memresp_rdy, bus.imemresp_val, bus.memreq_val, bus.imemreq_rdy} !== 4'b1100) begin
      miscompares++;
      $display("FAIL full_same_cycle: mrdy/ival/mval/irdy got %b want 1100", {bus.memresp_rdy, bus.imemresp_val, bus.memreq_val, bus.imemreq_rdy});
    end
    vectors++;
    if (bus.imemresp_msg.data !== e.data) begin
      miscompares++;
      $display("FAIL full_resp_data: got %h want %h", bus.imemresp_msg.data, e.data);
    end
    @(negedge clk);
    bus.memresp_val = 1'b0;
    #1;
    vectors++;
    if ({num_outstanding, bus.memreq_val, bus.imemreq_rdy} !== {3'd3, 2'b11}) begin
      miscompares++;
      $display("FAIL full_admit: count/val/irdy got %0d/%b/%b want 3/1/1", num_outstanding, bus.memreq_val, bus.imemreq_rdy);
    end
    sbq.push_back('{1'b0, ~32'h3010});
    @(negedge clk);
    drive_idle();
    test_responses_in_order();
  endtask

  task automatic test_resp_backpressure();
    drive_idle();
    bus.memreq_rdy  = 1'b1;
    bus.dmemreq_val = 1'b1;
    bus.dmemreq_msg = mk_req(32'h4000);
    #1;
    vectors++;
    if (bus.dmemreq_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_issue: drdy got %b want 1", bus.dmemreq_rdy);
    end
    sbq.push_back('{1'b1, 32'hCAFEF00D});
    @(negedge clk);
    drive_idle();
    bus.memresp_val  = 1'b1;
    bus.memresp_msg  = mk_resp(32'hCAFEF00D);
    bus.imemresp_rdy = 1'b1;
    bus.dmemresp_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if ({bus.memresp_rdy, bus.imemresp_val, num_outstanding} !== {2'b00, 3'd1}) begin
        miscompares++;
        $display("FAIL bp_stall[%0d]: mrdy/ival/count got %b/%b/%0d want 0/0/1", i, bus.memresp_rdy, bus.imemresp_val, num_outstanding);
      end
      @(negedge clk);
    end
    test_responses_in_order();
  endtask

  task automatic test_spurious();
    drive_idle();
    bus.memresp_val  = 1'b1;
    bus.memresp_msg  = mk_resp(32'hDEAD0001);
    bus.imemresp_rdy = 1'b1;
    bus.dmemresp_rdy = 1'b1;
    #1;
    vectors++;
    if ({bus.memresp_rdy, bus.imemresp_val, bus.dmemresp_val, resp_error} !== 4'b0000) begin
      miscompares++;
      $display("FAIL spurious_comb: mrdy/ival/dval/err got %b want 0000", {bus.memresp_rdy, bus.imemresp_val, bus.dmemresp_val, resp_error});
    end
    @(negedge clk);
    drive_idle();
    #1;
    vectors++;
    if (resp_error !== 1'b1) begin
      miscompares++;
      $display("FAIL spurious_set: err got %b want 1", resp_error);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (resp_error !== 1'b1) begin
      miscompares++;
      $display("FAIL spurious_sticky: err got %b want 1", resp_error);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_traffic();
    drive_idle();
    bus.memreq_rdy  = 1'b1;
    bus.imemreq_val = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.imemreq_msg = mk_req(32'h5100 + 32'(i * 4));
      @(negedge clk);
    end
    // Both valid with downstream stalled: dmem is favoured and gets locked.
    bus.memreq_rdy  = 1'b0;
    bus.dmemreq_val = 1'b1;
    bus.dmemreq_msg = mk_req(32'h6000);
    bus.imemreq_msg = mk_req(32'h5000);
    #1;
    vectors++;
    if ({num_outstanding, bus.memreq_msg.addr} !== {3'd2, 32'h6000}) begin
      miscompares++;
      $display("FAIL midrst_pre: count/addr got %0d/%h want 2/00006000", num_outstanding, bus.memreq_msg.addr);
    end
    @(negedge clk);
    reset            = 1'b0;
    bus.memreq_rdy   = 1'b1;
    bus.memresp_val  = 1'b1;
    bus.imemresp_rdy = 1'b1;
    bus.dmemresp_rdy = 1'b1;
    #1;
    vectors++;
    if ({num_outstanding, resp_error} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrst_state: {count,err} got %b want 0000", {num_outstanding, resp_error});
    end
    vectors++;
    if ({bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.memresp_rdy, bus.imemresp_val, bus.dmemresp_val} !== 6'b000000) begin
      miscompares++;
      $display("FAIL midrst_handshake: got %b want 000000", {bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.memresp_rdy, bus.imemresp_val, bus.dmemresp_val});
    end
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    bus.memresp_val = 1'b0;
    #1;
    vectors++;
    if ({bus.memreq_msg.addr, bus.imemreq_rdy, bus.dmemreq_rdy} !== {32'h5000, 2'b10}) begin
      miscompares++;
      $display("FAIL midrst_first: addr/irdy/drdy got %h/%b/%b want 00005000/1/0", bus.memreq_msg.addr, bus.imemreq_rdy, bus.dmemreq_rdy);
    end
    sbq.push_back('{1'b0, ~32'h5000});
    @(negedge clk);
    bus.imemreq_msg = mk_req(32'h5004);
    #1;
    vectors++;
    if ({bus.memreq_msg.addr, bus.dmemreq_rdy} !== {32'h6000, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_second: addr/drdy got %h/%b want 00006000/1", bus.memreq_msg.addr, bus.dmemreq_rdy);
    end
    sbq.push_back('{1'b1, ~32'h6000});
    @(negedge clk);
    drive_idle();
    test_responses_in_order();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_lock();
    test_full();
    test_resp_backpressure();
    test_spurious();
    test_reset_mid_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
